// File: rtl/load_store_unit_if.sv
// Word-wide req/ack data bus between load_store_unit (master) and data memory (slave).
interface load_store_unit_if;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic        i_bus_err;
    logic [31:0] i_bus_rdata;

    modport master (
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        input  i_bus_ack, i_bus_err, i_bus_rdata
    );

    modport slave (
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        output i_bus_ack, i_bus_err, i_bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Turns CPU load/store strobes into one word-aligned bus transaction, stalling the CPU until done.
// Optional: define MISALIGN_TRAP_EN to fault misaligned accesses without issuing them on the bus.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_write,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_memsize,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_stall,
    output logic              o_fault,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              req_q, req_d;

    logic              is_store;
    logic              access;
    logic              misaligned;
    logic              trap;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic              unused_sig;

    always_comb begin : decode
        is_store   = i_write & (i_memsize != 2'b00);
        access     = i_load | is_store;
        misaligned = 1'b0;
        unique case (i_funct3[1:0])
            2'b01:   misaligned = i_addr[0];
            2'b10:   misaligned = (i_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        trap = access & misaligned;
`else
        trap = 1'b0;
`endif
        lane_be    = 4'b1111;
        lane_wdata = i_wdata;
        if (is_store) begin
            unique case (i_memsize)
                2'b01: begin
                    lane_be    = 4'b0001 << i_addr[1:0];
                    lane_wdata = {4{i_wdata[7:0]}};
                end
                2'b10: begin
                    lane_be    = 4'b0011 << {i_addr[1], 1'b0};
                    lane_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = i_wdata;
                end
            endcase
        end
    end

    // funct3[2] (signedness) is handled by the CPU; misaligned only matters when trapping.
    assign unused_sig = ^{i_funct3, misaligned};

    always_comb begin : fsm
        state_d          = state_q;
        cnt_d            = '0;
        rdata_d          = rdata_q;
        fault_d          = 1'b0;
        o_stall          = 1'b0;
        bus.o_bus_we     = 1'b0;
        bus.o_bus_be     = '0;
        bus.o_bus_addr   = {i_addr[31:2], 2'b00};
        bus.o_bus_wdata  = lane_wdata;
        unique case (state_q)
            ST_IDLE: begin
                o_stall = access;
                if (trap) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else if (access) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                o_stall      = 1'b1;
                bus.o_bus_we = is_store;
                bus.o_bus_be = lane_be;
                cnt_d        = cnt_q + 1'b1;
                // Error outranks a simultaneous ack; ack on the last allowed cycle still completes.
                if (bus.i_bus_err) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else if (bus.i_bus_ack) begin
                    state_d = ST_DONE;
                    rdata_d = bus.i_bus_rdata >> {i_addr[1:0], 3'b000};
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_BUS);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            req_q   <= req_d;
        end
    end

    assign bus.o_bus_req = req_q;
    assign o_rdata       = rdata_q;
    assign o_fault       = fault_q;

endmodule
